// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit: opcode encodings,
// default latencies and opcode classification helpers.
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_DIV   = 4'd1,
    MD_DIVU  = 4'd2,
    MD_MULT  = 4'd3,
    MD_MULTU = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8,
    MD_MSUB  = 4'd9
  } md_op_e;

  localparam int unsigned MUL_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF = 10;

  // Opcodes that occupy the MDU for a multi-cycle operation.
  function automatic logic is_start_op(logic [3:0] op);
    case (op)
      MD_DIV, MD_DIVU, MD_MULT, MD_MULTU, MD_MSUB: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

  // Divide-class start ops use the longer latency.
  function automatic logic is_div_op(logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Unassigned codes 10..15 collapse to none.
  function automatic logic [3:0] md_sanitize(logic [3:0] op);
    return (op > MD_MSUB) ? MD_NONE : op;
  endfunction

endpackage

// File: rtl/md_busy_shadow.sv
// Shadow of the MDU busy countdown: loads the operation latency when a start
// op in E finds the unit idle, then counts down to zero.
module md_busy_shadow
  import md_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] md_type_e,
  output logic       start_now,
  output logic [3:0] busy_remain
);

  // A start op only launches when the countdown is idle.
  always_comb begin
    start_now = is_start_op(md_type_e) && (busy_remain == '0);
  end

  // Load on launch, otherwise count down and rest at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_remain <= '0;
    end else if (start_now) begin
      busy_remain <= is_div_op(md_type_e) ? 4'(DIV_LAT) : 4'(MUL_LAT);
    end else if (busy_remain != '0) begin
      busy_remain <= busy_remain - 4'd1;
    end
  end

endmodule

// File: rtl/md_issue_ctrl.sv
// Decode-side MD issue control: D-stage stall for MD-class instructions while
// the MDU is occupied, D->E opcode register, stall counter and busy checker.
// Build option: MDU_EARLY_RELEASE_EN releases a waiting MD instruction on the
// MDU's final busy cycle instead of once it is fully idle.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_type_d,
  input  logic        ext_stall,
  input  logic        mdu_start,
  input  logic        mdu_busy,
  output logic [3:0]  md_type_e,
  output logic        stall_d,
  output logic        md_stall,
  output logic [3:0]  busy_remain,
  output logic [31:0] stall_cycles,
  output logic        sync_err
);

`ifdef MDU_EARLY_RELEASE_EN
  // HI/LO are written at the edge ending the last busy cycle, so a reader
  // can leave D during that cycle.
  localparam logic [3:0] STALL_THR = 4'd2;
`else
  localparam logic [3:0] STALL_THR = 4'd1;
`endif

  logic       start_now;
  logic [3:0] md_d_s;

  md_busy_shadow #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_shadow (
    .clk         (clk),
    .reset       (reset),
    .md_type_e   (md_type_e),
    .start_now   (start_now),
    .busy_remain (busy_remain)
  );

  // Stall any MD-class instruction in D while the MDU is launching or busy.
  always_comb begin
    md_d_s   = md_sanitize(md_type_d);
    md_stall = (md_d_s != MD_NONE) && (start_now || (busy_remain >= STALL_THR));
    stall_d  = md_stall | ext_stall;
  end

  // E register with bubble insertion, saturating stall counter, sticky checker.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_type_e    <= '0;
      stall_cycles <= '0;
      sync_err     <= 1'b0;
    end else begin
      md_type_e <= stall_d ? '0 : md_d_s;
      if (md_stall && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if ((mdu_busy != (busy_remain != '0)) || (mdu_start != start_now)) begin
        sync_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Scoreboard bench for md_issue_ctrl: a driver applies directed and random
// instruction streams, predicts each cycle's outputs from a time-stamp model
// of MDU occupancy and queues them; a monitor compares on the falling edge.
module tb_md_issue_ctrl;

`ifdef MDU_EARLY_RELEASE_EN
  localparam int THR = 2;
  localparam int MUL_ST = 5;
  localparam int DIV_ST = 10;
`else
  localparam int THR = 1;
  localparam int MUL_ST = 6;
  localparam int DIV_ST = 11;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  md_type_d = '0;
  logic        ext_stall = 1'b0;
  logic        mdu_start = 1'b0;
  logic        mdu_busy = 1'b0;
  logic [3:0]  md_type_e;
  logic        stall_d;
  logic        md_stall;
  logic [3:0]  busy_remain;
  logic [31:0] stall_cycles;
  logic        sync_err;

  md_issue_ctrl #(
    .MUL_LAT (5),
    .DIV_LAT (10)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .md_type_d    (md_type_d),
    .ext_stall    (ext_stall),
    .mdu_start    (mdu_start),
    .mdu_busy     (mdu_busy),
    .md_type_e    (md_type_e),
    .stall_d      (stall_d),
    .md_stall     (md_stall),
    .busy_remain  (busy_remain),
    .stall_cycles (stall_cycles),
    .sync_err     (sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  e;
    logic        sd;
    logic        ms;
    logic [3:0]  br;
    logic [31:0] sc;
    logic        se;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // Reference model: the MDU is free from cycle free_at onward.
  int          cyc = 0;
  int          free_at = 0;
  logic [3:0]  m_e = '0;
  logic [31:0] m_cnt = '0;
  bit          m_err = 1'b0;
  bit          last_stall = 1'b0;
  int          last_remain = 0;
  logic [3:0]  cur_d = '0;

  function automatic logic [3:0] clean(logic [3:0] op);
    return (op > 4'd9) ? 4'd0 : op;
  endfunction

  function automatic bit starts(logic [3:0] op);
    return op == 4'd1 || op == 4'd2 || op == 4'd3 || op == 4'd4 || op == 4'd9;
  endfunction

  function automatic int lat_of(logic [3:0] op);
    return (op == 4'd1 || op == 4'd2) ? 10 : 5;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One pipeline cycle: drive inputs, queue predicted outputs, advance model.
  task automatic step(input logic [3:0] d, input bit ext, input bit rst,
                      input bit fault_busy, input bit fault_start);
    int remain;
    bit sn, mds, b_in, s_in;
    exp_t x;
    @(posedge clk);
    #1;
    cyc++;
    remain = (free_at > cyc) ? free_at - cyc : 0;
    sn  = starts(m_e) && remain == 0;
    mds = clean(d) != 4'd0 && (sn || remain >= THR);
    b_in = (remain != 0) ^ fault_busy;
    s_in = sn ^ fault_start;
    md_type_d = d;
    ext_stall = ext;
    reset     = rst;
    mdu_busy  = b_in;
    mdu_start = s_in;
    x.e = m_e; x.sd = mds | ext; x.ms = mds; x.br = 4'(remain);
    x.sc = m_cnt; x.se = m_err;
    q.push_back(x);
    last_stall  = mds | ext;
    last_remain = remain;
    cur_d = d;
    if (rst) begin
      free_at = 0; m_e = '0; m_cnt = '0; m_err = 1'b0;
    end else begin
      if (sn) free_at = cyc + 1 + lat_of(m_e);
      m_e = (mds | ext) ? 4'd0 : clean(d);
      if (mds && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if ((b_in != (remain != 0)) || (s_in != sn)) m_err = 1'b1;
    end
  endtask

  // Issue an MD op, then hold a dependent op in D until released.
  task automatic dep_pair(input logic [3:0] first, input logic [3:0] second,
                          input string name, input int exp_stalls);
    int n;
    step(4'd0, 0, 1, 0, 0);
    step(first, 0, 0, 0, 0);
    n = 0;
    do begin
      step(second, 0, 0, 0, 0);
      n++;
    end while (last_stall && n < 30);
    if (last_stall) check({name, "_release_timeout"}, 32'd1, 32'd0);
    step(4'd0, 0, 0, 0, 0);
    @(negedge clk);
    check(name, stall_cycles, 32'(exp_stalls));
  endtask

  // Monitor: compare every presented cycle against the queued prediction.
  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        check("md_type_e",    32'(md_type_e),   32'(x.e));
        check("stall_d",      32'(stall_d),     32'(x.sd));
        check("md_stall",     32'(md_stall),    32'(x.ms));
        check("busy_remain",  32'(busy_remain), 32'(x.br));
        check("stall_cycles", stall_cycles,     x.sc);
        check("sync_err",     32'(sync_err),    32'(x.se));
      end
    end
  end

  initial begin : driver
    int n, r;
    logic [3:0] d;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Dependent pairs with stall-count checks.
    dep_pair(4'd3, 4'd5, "mult_mfhi_stalls", MUL_ST);
    dep_pair(4'd2, 4'd8, "divu_mtlo_stalls", DIV_ST);
    dep_pair(4'd9, 4'd6, "msub_mflo_stalls", MUL_ST);

    // Non-MD traffic behind a divide, with an external stall pulse.
    step(4'd1, 0, 0, 0, 0);
    repeat (4) step(4'd0, 0, 0, 0, 0);
    step(4'd0, 1, 0, 0, 0);
    repeat (3) step(4'd12, 0, 0, 0, 0);

    // Reset in the middle of a divide.
    step(4'd0, 0, 1, 0, 0);
    step(4'd1, 0, 0, 0, 0);
    n = 0;
    do begin
      step(4'd0, 0, 0, 0, 0);
      n++;
    end while (last_remain != 3 && n < 30);
    step(4'd0, 0, 1, 0, 0);
    step(4'd0, 0, 0, 0, 0);
    @(negedge clk);
    check("reset_mid_busy", busy_remain, 32'd0);

    // Forced busy mismatch: sticky until reset.
    step(4'd0, 0, 0, 1, 0);
    repeat (5) step(4'd13, 0, 0, 0, 0);
    @(negedge clk);
    check("sync_err_sticky", 32'(sync_err), 32'd1);
    step(4'd0, 0, 1, 0, 0);
    step(4'd0, 0, 0, 0, 0);

    // Random stream; the D instruction is held while stalled.
    for (int i = 0; i < 3000; i++) begin
      if (last_stall) begin
        d = cur_d;
      end else begin
        r = $urandom_range(0, 99);
        if (r < 35)      d = 4'd0;
        else if (r < 90) d = 4'($urandom_range(1, 9));
        else             d = 4'($urandom_range(10, 15));
      end
      step(d, $urandom_range(0, 99) < 12, $urandom_range(0, 199) == 0,
           $urandom_range(0, 299) == 0, $urandom_range(0, 299) == 0);
    end
    step(4'd0, 0, 0, 0, 0);

    n = 0;
    while (q.size() > 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) check("queue_drain", 32'(q.size()), 32'd0);
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_issue_ctrl.md
# md_issue_ctrl

Decode-side initiator for the HI/LO multiply-divide unit (MDU). It owns the D→E pipeline register for the MD opcode and drives the MDU's `MDType` input. It keeps a shadow countdown that mirrors the MDU's internal busy counter, and uses it to generate the D-stage stall for any MD-class instruction while a multiply or divide is in flight. It also provides a stall-cycle performance counter and a sticky consistency check against the MDU's `Busy` output.

## Interface
Parameters:
- `MUL_LAT`, default 5: cycles an MDU multiply occupies (mult, multu, msub).
- `DIV_LAT`, default 10: cycles an MDU divide occupies (div, divu).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `md_type_d`  in  4  MD opcode of the instruction in D; 0 = none.
- `ext_stall`  in  1  stall request from the other hazard logic.
- `mdu_start`  in  1  MDU `Start` output.
- `mdu_busy`  in  1  MDU `Busy` output.
- `md_type_e`  out  4  registered opcode; drives MDU `MDType`.
- `stall_d`  out  1  freezes PC and the F/D register; a bubble is inserted into E.
- `md_stall`  out  1  the MD-induced part of `stall_d`.
- `busy_remain`  out  4  shadow countdown value.
- `stall_cycles`  out  32  count of cycles with `md_stall` = 1.
- `sync_err`  out  1  sticky shadow/MDU mismatch flag.

Reset: reset, synchronous, active-high; clock clk.

## Operation
- Opcodes:
  - none 0, div 1, divu 2, mult 3, multu 4, mfhi 5, mflo 6, mthi 7, mtlo 8, msub 9.
  - Codes 10–15 are treated as none on both input and output; `md_type_e` never carries them.
- Start op: `md_type_e` ∈ {div, divu, mult, multu, msub}.
- `start_now` = start op in E && `busy_remain` == 0. This is the shadow equivalent of `mdu_start`.
- Shadow counter:
  - If `start_now`: load `MUL_LAT` for mult/multu/msub, `DIV_LAT` for div/divu.
  - Else if nonzero: decrement.
  - Else: hold 0.
  - A start op in E while the counter is nonzero does not load the counter. This cannot occur when the stall rule is obeyed.
- `md_stall` = (`md_type_d` ≠ none) && (`start_now` || `busy_remain` ≥ THR). THR is set under Configuration.
- `stall_d` = `md_stall` | `ext_stall`.
- E register each cycle: if `stall_d`, `md_type_e` ← 0 (bubble); else `md_type_e` ← sanitized `md_type_d`.
- `stall_cycles` increments on every cycle with `md_stall` = 1 and saturates at 0xFFFFFFFF. Cycles stalled only by `ext_stall` are not counted.
- `sync_err` is set when `mdu_busy` ≠ (`busy_remain` ≠ 0), or when `mdu_start` ≠ `start_now`. It is cleared only by reset.

## Timing
- Reset values: `md_type_e` 0, `busy_remain` 0, `stall_cycles` 0, `sync_err` 0.
- `stall_d` and `md_stall` are combinational and therefore 0 immediately after reset unless `ext_stall` is asserted.
- Multiply issued into E at cycle t: `busy_remain` reads 5,4,3,2,1 over cycles t+1 … t+5, and 0 at t+6. The MDU writes HI/LO at the edge ending t+5.
- mfhi held in D from cycle t:
  - THR = 1: stalled cycles t … t+5 (6 cycles); in E at t+7.
  - THR = 2: stalled cycles t … t+4 (5 cycles); in E at t+6, reading the freshly written HI.
- Divide behaves the same way with 10 in place of 5.
- `ext_stall` and `md_stall` together: one bubble per cycle; the counter increments because `md_stall` = 1.
- `reset` mid-operation: the shadow counter clears in the same edge as the MDU state, so no `sync_err` results.
- Non-MD instructions are never stalled by this block.

## Configuration
- `MDU_EARLY_RELEASE_EN` defined: THR = 2. An MD instruction in D is released on the MDU's final busy cycle, since HI/LO are written at that edge.
- Not defined: THR = 1, the conservative behaviour. Release occurs only once the MDU is fully idle, one cycle later per MD dependency.

## Structure
- Shared package `md_pkg`:
  - The ten opcode constants (reused by the MDU).
  - `MUL_LAT` / `DIV_LAT` default values.
  - A start-op classification function.
- Sub-module `md_busy_shadow`: the load/decrement countdown and the `start_now` output, with latency parameters.
- Top level `md_issue_ctrl`: the stall logic, the E register, the counter and the checker.

## Test plan
- Reset sequence, then mult(3) in D with no `ext_stall` → `md_type_e` = 3 next cycle; `busy_remain` 5→1→0; `sync_err` stays 0 against a real MDU.
- mult then mfhi back-to-back → `stall_cycles` = 6 (no macro) or 5 (with macro); mfhi reaches E with HI equal to the product's upper 32 bits.
- divu(2) then mtlo → mtlo stalled for 11 or 10 cycles; `md_type_e` shows a bubble (0) every stalled cycle.
- Non-MD instruction following a div → `md_stall` = 0 throughout; `ext_stall` pulse still yields a bubble with the counter unchanged.
- Reset asserted while `busy_remain` = 3 → next cycle all outputs 0; MDU `Busy` = 0; `sync_err` = 0.
- Force `mdu_busy` = 1 while `busy_remain` = 0 → `sync_err` = 1 and stays set until reset; `md_type_d` = 12 → treated as none.
